// File: rtl/bit_demux_collector.sv
// bit_demux_collector
//   Steers single input bits into one of N lanes and assembles them into an
//   N-bit word. The word is offered downstream with a valid/ready handshake
//   once every lane has been written.
//
//   Lane selection per accepted bit:
//     mode = 0 : addressed, lane = in_sel (an in_sel >= N is accepted and dropped)
//     mode = 1 : sequential, lane = internal pointer, which wraps N-1 -> 0
//
//   Ports:
//     clk        clock, rising edge
//     rst        synchronous, active-high reset
//     mode       steering mode, sampled per accepted bit
//     in_valid   in_bit/in_sel valid
//     in_ready   a bit can be accepted this cycle (function of state and rst)
//     in_bit     data bit
//     in_sel     destination lane in addressed mode
//     out_word   assembled word (registered)
//     out_mask   lanes written in the current word (registered)
//     out_valid  word complete (registered)
//     out_ready  consumer accepts out_word
//     out_parity XOR of the presented word (only with BIT_DEMUX_COLLECTOR_PARITY_EN)
//
//   Optional feature macro: BIT_DEMUX_COLLECTOR_PARITY_EN
module bit_demux_collector #(
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic [SEL_W-1:0] in_sel,
    output logic [N-1:0]     out_word,
    output logic [N-1:0]     out_mask,
    output logic             out_valid,
    input  logic             out_ready
`ifdef BIT_DEMUX_COLLECTOR_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ptr_next;
    logic [SEL_W-1:0] lane;
    logic [N-1:0]     word_next;
    logic [N-1:0]     mask_next;
    logic             accept;
    logic             done;

    always_comb begin
        in_ready  = (state_q == COLLECT) && !rst;
        accept    = in_valid && in_ready;
        lane      = mode ? ptr : in_sel;
        word_next = out_word;
        mask_next = out_mask;
        ptr_next  = ptr;
        state_d   = state_q;

        // An out-of-range in_sel matches no lane, so the bit is silently dropped.
        for (int i = 0; i < N; i++) begin
            if (accept && (lane == SEL_W'(i))) begin
                word_next[i] = in_bit;
                mask_next[i] = 1'b1;
            end
        end

        if (accept && mode) begin
            ptr_next = (ptr == SEL_W'(N - 1)) ? '0 : ptr + SEL_W'(1);
        end

        // Only a write that fills the last empty lane completes the word;
        // rewriting a lane leaves the mask unchanged.
        done = accept && (&mask_next);

        case (state_q)
            COLLECT: if (done)      state_d = HOLD;
            HOLD:    if (out_ready) state_d = COLLECT;
            default:                state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= COLLECT;
            out_word  <= '0;
            out_mask  <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else begin
            state_q   <= state_d;
            out_valid <= (state_d == HOLD);
            if (state_q == HOLD) begin
                // Handshake clears the bookkeeping; out_word keeps its last
                // value until lanes are rewritten.
                if (out_ready) begin
                    out_mask <= '0;
                    ptr      <= '0;
                end
            end else begin
                out_word <= word_next;
                out_mask <= mask_next;
                ptr      <= ptr_next;
            end
        end
    end

`ifdef BIT_DEMUX_COLLECTOR_PARITY_EN
    // Parity is captured on the same edge that raises out_valid and is then
    // held for the whole HOLD period, since out_word cannot change there.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_parity <= 1'b0;
        end else if (done) begin
            out_parity <= ^word_next;
        end
    end
`endif

endmodule
